// File: rtl/fixed_mul_pipe_pkg.sv
// rtl/fixed_mul_pipe_pkg.sv - shared types and Q-format helpers for the fixed-point datapath
package fixed_mul_pipe_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // value is sized for the widest supported result; callers keep the low width bits
  typedef struct packed {
    logic        ovf;
    logic [31:0] value;
  } sat_result_t;

  function automatic logic signed [63:0] q_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] q_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Narrow a shifted product to w bits: clamp or wrap, overflow flagged either way
  function automatic sat_result_t sat_narrow(input logic signed [63:0] r,
                                             input int unsigned       w,
                                             input logic              saturate);
    sat_result_t      res;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi        = q_max(w);
    lo        = q_min(w);
    res.ovf   = (r > hi) || (r < lo);
    res.value = r[31:0];
    if (saturate && (r > hi)) begin
      res.value = hi[31:0];
    end else if (saturate && (r < lo)) begin
      res.value = lo[31:0];
    end
    return res;
  endfunction

  // Original Q10 multiply for combinational users: truncating, wrapping
  function automatic logic signed [31:0] mul_frac10_32b(input logic signed [31:0] a,
                                                        input logic signed [31:0] b);
    logic signed [63:0] p;
    p = a * b;
    p = p >>> 10;
    return p[31:0];
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// rtl/fixed_round_sat.sv - combinational rounding, arithmetic shift, saturation and overflow
// prod : full-width signed product in
// data : DATA_WIDTH Q result out
// ovf  : shifted product outside the signed DATA_WIDTH range
module fixed_round_sat
  import fixed_mul_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input  logic signed [2*DATA_WIDTH-1:0] prod,
  output logic        [DATA_WIDTH-1:0]   data,
  output logic                           ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  // Half an LSB added before the floor shift gives round-half-toward-+inf.
  // The largest product magnitude is 2^(PW-2), so the bias cannot overflow PW bits.
  localparam logic signed [PW-1:0] RND_ADD =
    (ROUND_MODE == int'(RND_HALF_UP)) ? (PW'(1) <<< (FRAC_BITS - 1)) : '0;

  logic signed [PW-1:0] biased;
  logic signed [PW-1:0] shifted;
  logic signed [63:0]   wide;
  sat_result_t          sat;

  always_comb begin
    biased  = prod + RND_ADD;
    shifted = biased >>> FRAC_BITS;
    wide    = 64'(shifted);
    sat     = sat_narrow(wide, DATA_WIDTH, SATURATE != 0);
    data    = sat.value[DATA_WIDTH-1:0];
    ovf     = sat.ovf;
  end

endmodule

// File: rtl/fixed_mul_pipe.sv
// rtl/fixed_mul_pipe.sv - pipelined signed fixed-point multiplier with valid/ready and tag sideband
// clock, reset            : single domain, synchronous active-high reset
// in_valid/in_ready       : operand handshake, in_a/in_b signed Q operands, in_tag sideband
// out_valid/out_ready     : result handshake, out_data Q result, out_ovf range flag, out_tag
module fixed_mul_pipe
  import fixed_mul_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 10,
  parameter int PIPE_STAGES = 3,
  parameter int ROUND_MODE  = 0,
  parameter int SATURATE    = 1,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  input  logic        [TAG_WIDTH-1:0]  in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic                         out_ovf,
  output logic        [TAG_WIDTH-1:0]  out_tag
);

  localparam int N    = PIPE_STAGES;
  localparam int NMID = (N > 2) ? N - 2 : 1;  // product-carrying stages 2..N-1
  localparam int PW   = 2 * DATA_WIDTH;

  logic [N:1]                  valid_q, valid_d, load;
  logic [TAG_WIDTH-1:0]        tag_q  [1:N];
  logic [TAG_WIDTH-1:0]        tag_d  [1:N];
  logic signed [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic signed [PW-1:0]        prod_q [NMID];
  logic signed [PW-1:0]        prod_d [NMID];
  logic [DATA_WIDTH-1:0]       res_q, res_d;
  logic                        ovf_q, ovf_d;

  logic signed [PW-1:0]        mul_full;
  logic signed [PW-1:0]        rs_prod;
  logic [DATA_WIDTH-1:0]       rs_data;
  logic                        rs_ovf;

  assign mul_full = a_q * b_q;
  // With two stages the multiply feeds rounding directly in front of the output register
  assign rs_prod  = (N == 2) ? mul_full : prod_q[NMID-1];

  fixed_round_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ROUND_MODE(ROUND_MODE),
    .SATURATE  (SATURATE)
  ) u_round_sat (
    .prod(rs_prod),
    .data(rs_data),
    .ovf (rs_ovf)
  );

  // Ready ripples back from the output: a stage loads when empty or when it is moving on.
  always_comb begin
    logic ready_chain;
    ready_chain = out_ready;
    load        = '0;
    for (int k = N; k >= 1; k--) begin
      ready_chain = !valid_q[k] || ready_chain;
      load[k]     = ready_chain;
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    if (load[1]) begin
      valid_d[1] = in_valid;
      if (in_valid) begin
        a_d      = in_a;
        b_d      = in_b;
        tag_d[1] = in_tag;
      end
    end

    for (int k = 2; k <= N; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          tag_d[k] = tag_q[k-1];
        end
      end
    end

    if ((N > 2) && load[2] && valid_q[1]) begin
      prod_d[0] = mul_full;
    end
    for (int m = 1; m < NMID; m++) begin
      if (load[m+2] && valid_q[m+1]) begin
        prod_d[m] = prod_q[m-1];
      end
    end

    if (load[N] && valid_q[N-1]) begin
      res_d = rs_data;
      ovf_d = rs_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '{default: '0};
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  // Gating with reset keeps a flushed result from looking transferable during the reset cycle
  assign in_ready  = !reset && load[1];
  assign out_valid = !reset && valid_q[N];
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;
  assign out_tag   = tag_q[N];

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// tb/tb_fixed_mul_pipe.sv - self-checking bench for fixed_mul_pipe
module tb_fixed_mul_pipe;

  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int NRAND = 1000;
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;

  logic          in_ready, out_valid, out_ovf;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          in_ready_r, out_valid_r, out_ovf_r;
  logic [DW-1:0] out_data_r;
  logic [TW-1:0] out_tag_r;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] dd;
    logic          od;
    logic [DW-1:0] dr;
    logic          orr;
    logic [TW-1:0] tag;
  } exp_t;

  logic [DW-1:0] dir_a  [6] = '{32'd1536, -32'sd1536, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
  logic [DW-1:0] dir_b  [6] = '{32'd2048, 32'd2048, 32'd512, 32'd512, 32'd2048, -32'sd1024};
  logic [DW-1:0] dir_dd [6] = '{32'd3072, -32'sd3072, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
  logic          dir_od [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [DW-1:0] dir_dr [6] = '{32'd3072, -32'sd3072, 32'd1, 32'd0, 32'hFFFFFFFE, 32'h80000000};
  logic          dir_or [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [DW-1:0] edge_vals [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h400};

  fixed_mul_pipe #(
    .DATA_WIDTH(DW), .FRAC_BITS(10), .PIPE_STAGES(3),
    .ROUND_MODE(0), .SATURATE(1), .TAG_WIDTH(TW)
  ) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  fixed_mul_pipe #(
    .DATA_WIDTH(DW), .FRAC_BITS(10), .PIPE_STAGES(3),
    .ROUND_MODE(1), .SATURATE(0), .TAG_WIDTH(TW)
  ) u_rw (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_r),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .out_ovf(out_ovf_r), .out_tag(out_tag_r)
  );

  always #5 clock = ~clock;

  // Reference: exact product, optional half-LSB bias, floor divide by 2^10, then clamp or wrap
  function automatic void ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input bit rnd, input bit sat,
                                  output logic [DW-1:0] d, output logic o);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + 512;
    r = p >>> 10;
    o = (r > QMAX) || (r < QMIN);
    if (sat && (r > QMAX))      d = 32'h7FFFFFFF;
    else if (sat && (r < QMIN)) d = 32'h80000000;
    else                        d = r[31:0];
  endfunction

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 65535)) - 32'd32768;
      2:       return edge_vals[$urandom_range(0, 5)];
      default: return 32'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    checks += 6;
    if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_valid_r !== 1'b0) begin failures++; $display("FAIL reset_out_valid_r got %b want 0", out_valid_r); end
    if (out_data !== '0)      begin failures++; $display("FAIL reset_out_data got %h want 0", out_data); end
    if (out_ovf !== 1'b0)     begin failures++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    if (out_tag !== '0)       begin failures++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    if (in_ready !== 1'b0)    begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = dir_a[i]; in_b = dir_b[i]; in_tag = TW'(i); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL dir_in_ready[%0d] got %b want 1", i, in_ready); end
      @(posedge clock); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clock); #1;
        lat++;
      end
      checks += 6;
      if (lat != 3) begin failures++; $display("FAIL dir_latency[%0d] got %0d want 3", i, lat); end
      if (out_data !== dir_dd[i])   begin failures++; $display("FAIL dir_data[%0d] got %h want %h", i, out_data, dir_dd[i]); end
      if (out_ovf !== dir_od[i])    begin failures++; $display("FAIL dir_ovf[%0d] got %b want %b", i, out_ovf, dir_od[i]); end
      if (out_data_r !== dir_dr[i]) begin failures++; $display("FAIL dir_data_rw[%0d] got %h want %h", i, out_data_r, dir_dr[i]); end
      if (out_ovf_r !== dir_or[i])  begin failures++; $display("FAIL dir_ovf_rw[%0d] got %b want %b", i, out_ovf_r, dir_or[i]); end
      if (out_tag !== TW'(i))       begin failures++; $display("FAIL dir_tag[%0d] got %h want %h", i, out_tag, TW'(i)); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    int cyc = 0;
    int gaps = 0;
    while (got < 8 && cyc < 60) begin
      out_ready = (cyc >= 5);
      in_valid  = (acc < 8);
      in_a      = 32'(100 + acc);
      in_b      = 32'd1024;
      in_tag    = TW'(acc);
      #1;
      if (cyc == 4) begin
        checks += 2;
        if (acc != 3)          begin failures++; $display("FAIL bp_accepts got %0d want 3", acc); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
      end
      if (cyc >= 5 && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        checks += 3;
        if (out_data !== 32'(100 + got))   begin failures++; $display("FAIL bp_data got %h want %h", out_data, 32'(100 + got)); end
        if (out_data_r !== 32'(100 + got)) begin failures++; $display("FAIL bp_data_rw got %h want %h", out_data_r, 32'(100 + got)); end
        if (out_tag !== TW'(got))          begin failures++; $display("FAIL bp_tag got %h want %h", out_tag, TW'(got)); end
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks += 2;
    if (got != 8)  begin failures++; $display("FAIL bp_count got %0d want 8", got); end
    if (gaps != 0) begin failures++; $display("FAIL bp_gaps got %0d want 0", gaps); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   sent = 0;
    int   rcvd = 0;
    int   cyc  = 0;
    bit   fired;
    in_valid = 1'b0;
    while (rcvd < NRAND && cyc < 20000) begin
      if (!in_valid && sent < NRAND && $urandom_range(0, 99) < 70) begin
        in_a = rand_operand(); in_b = rand_operand();
        in_tag = TW'($urandom_range(0, 3)); in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (out_valid_r !== out_valid || in_ready_r !== in_ready) begin
        failures++;
        $display("FAIL rand_lockstep got v=%b/%b r=%b/%b want equal", out_valid, out_valid_r, in_ready, in_ready_r);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rand_spurious got data %h want no output", out_data);
        end else begin
          e = q.pop_front();
          checks += 5;
          if (out_data !== e.dd)   begin failures++; $display("FAIL rand_data[%0d] got %h want %h", rcvd, out_data, e.dd); end
          if (out_ovf !== e.od)    begin failures++; $display("FAIL rand_ovf[%0d] got %b want %b", rcvd, out_ovf, e.od); end
          if (out_data_r !== e.dr) begin failures++; $display("FAIL rand_data_rw[%0d] got %h want %h", rcvd, out_data_r, e.dr); end
          if (out_ovf_r !== e.orr) begin failures++; $display("FAIL rand_ovf_rw[%0d] got %b want %b", rcvd, out_ovf_r, e.orr); end
          if (out_tag !== e.tag)   begin failures++; $display("FAIL rand_tag[%0d] got %h want %h", rcvd, out_tag, e.tag); end
          rcvd++;
        end
      end
      fired = in_valid && in_ready;
      if (fired) begin
        ref_mul(in_a, in_b, 1'b0, 1'b1, e.dd, e.od);
        ref_mul(in_a, in_b, 1'b1, 1'b0, e.dr, e.orr);
        e.tag = in_tag;
        q.push_back(e);
        sent++;
      end
      @(posedge clock); #1;
      cyc++;
      if (fired) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rcvd != NRAND) begin failures++; $display("FAIL rand_count got %0d want %0d", rcvd, NRAND); end
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'(1024 * (i + 1)); in_b = 32'd1024; in_tag = TW'(i); in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    checks += 2;
    if (out_valid !== 1'b0)   begin failures++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
    if (out_valid_r !== 1'b0) begin failures++; $display("FAIL mr_out_valid_rw got %b want 0", out_valid_r); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_in_ready got %b want 1", in_ready); end
    for (int c = 0; c < 6; c++) begin
      if (out_valid || out_valid_r) stale++;
      @(posedge clock); #1;
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL mr_stale got %0d want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_mul_pipe.md
Name: fixed_mul_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier. It is the streaming successor to the package-level Q10 multiply function, for the FM datapath: demodulator, FIR, de-emphasis gain.
Adds configurable width, fraction bits, pipeline depth, rounding mode, saturation with overflow flag, valid/ready backpressure and a sideband tag (e.g. I/Q or channel id).
Sits between any two streaming stages; one product per cycle at full throughput.

Parameters:
DATA_WIDTH, 32, operand and result width (signed two's complement), 8..32
FRAC_BITS, 10, fractional bits of operands and result (Q format), 1..DATA_WIDTH-1
PIPE_STAGES, 3, accept-to-output latency in cycles, 2..6
ROUND_MODE, 0, 0 = truncate (arithmetic shift, floor); 1 = round half toward +inf
SATURATE, 1, 1 = clamp on overflow; 0 = wrap (keep low DATA_WIDTH bits)
TAG_WIDTH, 2, sideband width carried alongside data, >=1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
in_a  in  DATA_WIDTH  signed operand A
in_b  in  DATA_WIDTH  signed operand B
in_tag  in  TAG_WIDTH  sideband, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_WIDTH  signed Q result
out_ovf  out  1  result exceeded signed DATA_WIDTH range (flagged in both SATURATE modes)
out_tag  out  TAG_WIDTH  tag matching out_data

Behaviour:
- Reset: clock and reset are one clock domain; reset is synchronous and active-high.
  - All stage valids clear on the first edge with reset=1.
  - out_valid=0, out_data=0, out_ovf=0, out_tag=0 while reset is held.
  - in_ready=0 while reset is high; in_ready=1 on the cycle after reset deasserts.
- Transfer rule: transfer occurs when valid && ready. Data stays stable while valid && !ready.
- Stage structure:
  - Stage 1 registers a, b, tag.
  - Middle stages carry the full 2*DATA_WIDTH signed product.
  - The last stage registers the rounded/saturated result.
  - With PIPE_STAGES=2, multiply and round/sat sit in front of the stage-2 register.
- Latency: exactly PIPE_STAGES cycles from accept edge to out_valid when out_ready=1. Throughput is 1/cycle.
- Pipeline advance:
  - Stage k loads when stage k is empty or stage k is advancing.
  - in_ready = !stage1_valid || stage1_advances. This is bubble-collapsing, with no combinational path from in_valid to in_ready.
  - The out_ready-to-in_ready combinational path is permitted.
- Arithmetic:
  - p = signed(a)*signed(b), 2*DATA_WIDTH bits.
  - ROUND_MODE=1: p += 2^(FRAC_BITS-1) before the shift.
  - r = p >>> FRAC_BITS (arithmetic shift).
  - ovf = r outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - SATURATE=1: out_data clamps to max or min.
  - SATURATE=0: out_data = r[DATA_WIDTH-1:0].
- Ordering: results leave in accept order, and each tag stays bound to its data.
- Stall: with out_ready=0, all PIPE_STAGES slots fill, then in_ready=0. No item is dropped or duplicated.
- Simultaneous events: accept and emit in the same cycle are allowed when full and out_ready=1.
- Reset mid-operation flushes all in-flight items. Nothing is emitted after reset.

Decomposition:
- Package func gains:
  - typedef enum round_mode_e {RND_TRUNC, RND_HALF_UP}
  - localparam helpers for q_max/q_min per width
  - function sat_narrow (2W to W, returns value and ovf)
- Existing mul_frac10_32b stays for combinational users.
- One sub-module: fixed_round_sat. It is combinational and does the shift, rounding, saturation and ovf; it is instantiated in the last stage.
- Handshake control is a generic per-stage valid chain inside fixed_mul_pipe.

Test Plan:
- Defaults, a=1536 (1.5), b=2048 (2.0), out_ready=1 -> out_data=3072, ovf=0, out_valid exactly 3 cycles after accept. Repeat with a=-1536 -> -3072.
- Rounding, a=1, b=512: ROUND_MODE=0 gives 0, ROUND_MODE=1 gives 1. a=-1, b=512: truncate gives -1, round gives 0.
- Overflow:
  - a=0x7FFFFFFF, b=2048 with SATURATE=1 -> 0x7FFFFFFF, ovf=1; with SATURATE=0 -> 0xFFFFFFFE, ovf=1.
  - a=0x80000000, b=-1024 with SATURATE=1 -> 0x7FFFFFFF, ovf=1.
- Backpressure: continuous in_valid with incrementing a and tags, out_ready low for 5 cycles.
  - in_ready drops after 3 accepts.
  - After release, all results arrive in order with matching tags and no gaps at full rate.
- Random out_ready (50%) over 1000 random operand pairs versus a reference model -> bit-exact data, ovf and tag, in order.
- Reset asserted for one cycle with 3 items in flight -> out_valid=0 the following cycle, no stale result emitted, in_ready=1 one cycle after reset deasserts.
